apb_reg_slave: RTL and testbench



---
 rtl/apb_reg_pkg.sv | 24 ++
 rtl/apb_reg_slave_if.sv | 26 ++
 rtl/apb_reg_decode.sv | 45 ++++
 rtl/apb_reg_slave.sv | 180 ++++++++++++++++++
 tb/tb_apb_reg_slave.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_reg_pkg.sv
// Shared types and constants for the APB register slave and its address decoder.
package apb_reg_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ErrOk       = 2'd0,
    ErrMisalign = 2'd1,
    ErrUnmapped = 2'd2,
    ErrRoWrite  = 2'd3
  } err_e;

  localparam int unsigned REG_BYTES = 4;

  // Register index width; never zero so a single-register bank still has a valid index.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_reg_slave_if.sv
// APB3 bus bundle between the CDC bridge destination side and the register slave.
interface apb_reg_slave_if #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32
) ();

  logic [APB_ADDR_WIDTH-1:0] PADDR_i;
  logic [APB_DATA_WIDTH-1:0] PWDATA_i;
  logic                      PWRITE_i;
  logic                      PSEL_i;
  logic                      PENABLE_i;
  logic [APB_DATA_WIDTH-1:0] PRDATA_o;
  logic                      PREADY_o;
  logic                      PSLVERR_o;

  modport master (
    output PADDR_i, PWDATA_i, PWRITE_i, PSEL_i, PENABLE_i,
    input  PRDATA_o, PREADY_o, PSLVERR_o
  );

  modport slave (
    input  PADDR_i, PWDATA_i, PWRITE_i, PSEL_i, PENABLE_i,
    output PRDATA_o, PREADY_o, PSLVERR_o
  );

endinterface

// File: rtl/apb_reg_decode.sv
// Combinational word-register address decode: RW bank, trailing status word, error cause.
module apb_reg_decode
  import apb_reg_pkg::*;
#(
  parameter int unsigned               APB_ADDR_WIDTH = 32,
  parameter int unsigned               NUM_REGS       = 8,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned               IDX_WIDTH      = idx_width(NUM_REGS)
) (
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic                      pwrite_i,
  output logic [IDX_WIDTH-1:0]      idx_o,
  output logic                      hit_rw_o,
  output logic                      hit_status_o,
  output err_e                      err_cause_o
);

  localparam int unsigned      ByteBits = $clog2(REG_BYTES);
  localparam int unsigned      WordW    = APB_ADDR_WIDTH - ByteBits;
  localparam logic [WordW-1:0] NumRegsW = WordW'(NUM_REGS);

  logic [APB_ADDR_WIDTH-1:0] off;
  logic [WordW-1:0]          word;
  logic                      below;

  always_comb begin
    off          = paddr_i - BASE_ADDR;
    word         = off[APB_ADDR_WIDTH-1:ByteBits];
    below        = paddr_i < BASE_ADDR;
    idx_o        = word[IDX_WIDTH-1:0];
    hit_rw_o     = !below && (word < NumRegsW);
    hit_status_o = !below && (word == NumRegsW);
    // Misalignment wins over every other cause.
    if (off[ByteBits-1:0] != '0) begin
      err_cause_o = ErrMisalign;
    end else if (!hit_rw_o && !hit_status_o) begin
      err_cause_o = ErrUnmapped;
    end else if (hit_status_o && pwrite_i) begin
      err_cause_o = ErrRoWrite;
    end else begin
      err_cause_o = ErrOk;
    end
  end

endmodule

// File: rtl/apb_reg_slave.sv
// APB3 register bank: NUM_REGS RW words, one RO status word, programmable wait states.
module apb_reg_slave
  import apb_reg_pkg::*;
#(
  parameter int unsigned               APB_DATA_WIDTH = 32,
  parameter int unsigned               APB_ADDR_WIDTH = 32,
  parameter int unsigned               NUM_REGS       = 8,
  parameter int unsigned               WAIT_CYCLES    = 1,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  apb_reg_slave_if.slave                     apb,
  input  logic [APB_DATA_WIDTH-1:0]          status_i,
  output logic [NUM_REGS*APB_DATA_WIDTH-1:0] reg_q_o,
  output logic [NUM_REGS-1:0]                wr_pulse_o
);

  localparam int unsigned IdxW    = idx_width(NUM_REGS);
  localparam logic [3:0]  CntInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic                      err_q, err_d, wr_ok_q, wr_ok_d, stat_q, stat_d, write_q, write_d;
  logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d, status_q, status_d, prdata_q, prdata_d;
  logic                      pslverr_q, pslverr_d;
  logic [NUM_REGS-1:0]       wr_pulse_q, wr_pulse_d;
  logic [APB_DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [APB_DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                      setup;
  logic [IdxW-1:0]           dec_idx, cur_idx;
  logic                      dec_hit_rw, dec_hit_status;
  err_e                      dec_err;
  logic                      cur_err, cur_write, cur_stat;
  logic [APB_DATA_WIDTH-1:0] cur_status;

  assign setup = apb.PSEL_i & ~apb.PENABLE_i;

  apb_reg_decode #(
    .APB_ADDR_WIDTH(APB_ADDR_WIDTH),
    .NUM_REGS      (NUM_REGS),
    .BASE_ADDR     (BASE_ADDR),
    .IDX_WIDTH     (IdxW)
  ) u_decode (
    .paddr_i     (apb.PADDR_i),
    .pwrite_i    (apb.PWRITE_i),
    .idx_o       (dec_idx),
    .hit_rw_o    (dec_hit_rw),
    .hit_status_o(dec_hit_status),
    .err_cause_o (dec_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      wr_ok_q    <= 1'b0;
      stat_q     <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      status_q   <= '0;
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
      wr_pulse_q <= '0;
      regs_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      wr_ok_q    <= wr_ok_d;
      stat_q     <= stat_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      status_q   <= status_d;
      prdata_q   <= prdata_d;
      pslverr_q  <= pslverr_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (setup) begin
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (!apb.PSEL_i) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    idx_d      = idx_q;
    err_d      = err_q;
    wr_ok_d    = wr_ok_q;
    stat_d     = stat_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    status_d   = status_q;
    prdata_d   = prdata_q;
    pslverr_d  = pslverr_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;

    if (state_q == StIdle && setup) begin
      idx_d    = dec_idx;
      err_d    = dec_err != ErrOk;
      wr_ok_d  = (dec_err == ErrOk) && apb.PWRITE_i && dec_hit_rw;
      stat_d   = dec_hit_status;
      write_d  = apb.PWRITE_i;
      wdata_d  = apb.PWDATA_i;
      status_d = status_i;
    end

    // Zero-wait transfers enter RESP straight from IDLE, before the latches hold anything.
    if (state_q == StIdle) begin
      cur_idx    = dec_idx;
      cur_err    = dec_err != ErrOk;
      cur_write  = apb.PWRITE_i;
      cur_stat   = dec_hit_status;
      cur_status = status_i;
    end else begin
      cur_idx    = idx_q;
      cur_err    = err_q;
      cur_write  = write_q;
      cur_stat   = stat_q;
      cur_status = status_q;
    end

    if (state_d == StResp && state_q != StResp) begin
      pslverr_d = cur_err;
      if (cur_err || cur_write) begin
        prdata_d = '0;
      end else if (cur_stat) begin
        prdata_d = cur_status;
      end else begin
        prdata_d = regs_q[cur_idx];
      end
    end

    if (state_q == StResp && wr_ok_q && apb.PSEL_i && apb.PENABLE_i) begin
      regs_d[idx_q]     = wdata_q;
      wr_pulse_d[idx_q] = 1'b1;
    end
  end

  always_comb begin
    apb.PREADY_o  = state_q == StResp;
    apb.PSLVERR_o = pslverr_q && (state_q == StResp);
    apb.PRDATA_o  = prdata_q;
    wr_pulse_o    = wr_pulse_q;
    for (int k = 0; k < NUM_REGS; k++) begin
      reg_q_o[k*APB_DATA_WIDTH +: APB_DATA_WIDTH] = regs_q[k];
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: three instances (0, 1 and 3 wait states) share one driven APB bus.
module tb_apb_reg_slave;

  localparam logic [31:0] Base = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] paddr = '0, pwdata = '0, status = '0;
  logic        pwrite = 1'b0, psel = 1'b0, penable = 1'b0;
  int          sel = 0;
  int          wc_of [3] = '{0, 1, 3};

  always #5 clk = ~clk;

  apb_reg_slave_if if_w0 ();
  apb_reg_slave_if if_w1 ();
  apb_reg_slave_if if_w3 ();

  assign if_w0.PADDR_i = paddr;   assign if_w1.PADDR_i = paddr;   assign if_w3.PADDR_i = paddr;
  assign if_w0.PWDATA_i = pwdata; assign if_w1.PWDATA_i = pwdata; assign if_w3.PWDATA_i = pwdata;
  assign if_w0.PWRITE_i = pwrite; assign if_w1.PWRITE_i = pwrite; assign if_w3.PWRITE_i = pwrite;
  assign if_w0.PENABLE_i = penable;
  assign if_w1.PENABLE_i = penable;
  assign if_w3.PENABLE_i = penable;
  assign if_w0.PSEL_i = psel && (sel == 0);
  assign if_w1.PSEL_i = psel && (sel == 1);
  assign if_w3.PSEL_i = psel && (sel == 2);

  logic [255:0] regq0, regq1, regq3;
  logic [7:0]   pulse0, pulse1, pulse3;

  apb_reg_slave #(.WAIT_CYCLES(0), .BASE_ADDR(Base)) u_dut_w0 (
    .clk(clk), .rst(rst), .apb(if_w0.slave), .status_i(status),
    .reg_q_o(regq0), .wr_pulse_o(pulse0)
  );
  apb_reg_slave #(.WAIT_CYCLES(1), .BASE_ADDR(Base)) u_dut_w1 (
    .clk(clk), .rst(rst), .apb(if_w1.slave), .status_i(status),
    .reg_q_o(regq1), .wr_pulse_o(pulse1)
  );
  apb_reg_slave #(.WAIT_CYCLES(3), .BASE_ADDR(Base)) u_dut_w3 (
    .clk(clk), .rst(rst), .apb(if_w3.slave), .status_i(status),
    .reg_q_o(regq3), .wr_pulse_o(pulse3)
  );

  logic         cur_ready, cur_err;
  logic [31:0]  cur_rdata;
  logic [255:0] cur_regq;
  logic [7:0]   cur_pulse;

  always_comb begin
    cur_ready = if_w0.PREADY_o;  cur_err = if_w0.PSLVERR_o; cur_rdata = if_w0.PRDATA_o;
    cur_regq  = regq0;           cur_pulse = pulse0;
    if (sel == 1) begin
      cur_ready = if_w1.PREADY_o; cur_err = if_w1.PSLVERR_o; cur_rdata = if_w1.PRDATA_o;
      cur_regq  = regq1;          cur_pulse = pulse1;
    end else if (sel == 2) begin
      cur_ready = if_w3.PREADY_o; cur_err = if_w3.PSLVERR_o; cur_rdata = if_w3.PRDATA_o;
      cur_regq  = regq3;          cur_pulse = pulse3;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    bit          chk_rd;
    int          lat;
  } exp_t;

  typedef struct {
    int          s;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    logic [7:0]  pulse;
  } vec_t;

  exp_t        sb [$];
  vec_t        vecs [$];
  logic [31:0] mdl [3][8];
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input int s);
    sel = s;
    #1;
  endtask

  task automatic check_regs(input int s);
    logic [255:0] f;
    for (int k = 0; k < 8; k++) f[k*32 +: 32] = mdl[s][k];
    set_sel(s);
    check("reg_q", cur_regq, f);
  endtask

  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d, input exp_t e,
                      output logic [7:0] pls);
    exp_t got;
    int   n;
    sb.push_back(e);
    paddr = a; pwdata = d; pwrite = wr; psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    n = 1;
    while (!cur_ready && n < 20) begin
      tick();
      n++;
    end
    got = sb.pop_front();
    check("pready_timeout", cur_ready, 1);
    check("latency", n, got.lat);
    if (got.chk_rd) check("prdata", cur_rdata, got.rdata);
    check("pslverr", cur_err, got.err);
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    pls = cur_pulse;
  endtask

  function automatic vec_t mk(int s, bit wr, logic [31:0] a, logic [31:0] wd, logic [31:0] rd,
                              bit err, logic [7:0] pulse);
    vec_t v;
    v.s = s; v.wr = wr; v.addr = a; v.wdata = wd; v.rdata = rd; v.err = err; v.pulse = pulse;
    return v;
  endfunction

  function automatic exp_t mk_exp(int lat, bit wr, logic [31:0] rd, bit err);
    exp_t e;
    e.lat = lat; e.rdata = rd; e.err = err; e.chk_rd = !wr || err;
    return e;
  endfunction

  initial begin
    logic [7:0] pls;
    int         seen;

    foreach (mdl[s, k]) mdl[s][k] = '0;
    status = 32'h1234_5678;

    vecs.push_back(mk(1, 1, Base + 32'h4, 32'hDEAD_BEEF, 32'h0, 0, 8'h02));
    vecs.push_back(mk(1, 0, Base + 32'h4, 32'h0, 32'hDEAD_BEEF, 0, 8'h00));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 1, Base + 32'(4 * i), 32'h100 + 32'(i), 32'h0, 0, 8'(1 << i)));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 0, Base + 32'(4 * i), 32'h0, 32'h100 + 32'(i), 0, 8'h00));
    vecs.push_back(mk(0, 0, Base + 32'h20, 32'h0, 32'h1234_5678, 0, 8'h00));
    vecs.push_back(mk(0, 1, Base + 32'h20, 32'hFFFF_FFFF, 32'h0, 1, 8'h00));
    vecs.push_back(mk(0, 0, Base + 32'h24, 32'h0, 32'h0, 1, 8'h00));
    vecs.push_back(mk(0, 1, Base + 32'h24, 32'h5A5A, 32'h0, 1, 8'h00));
    vecs.push_back(mk(0, 1, Base + 32'h6, 32'h77, 32'h0, 1, 8'h00));
    vecs.push_back(mk(0, 0, Base + 32'h6, 32'h0, 32'h0, 1, 8'h00));
    vecs.push_back(mk(0, 0, Base - 32'h4, 32'h0, 32'h0, 1, 8'h00));
    vecs.push_back(mk(1, 0, Base + 32'h20, 32'h0, 32'h1234_5678, 0, 8'h00));

    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      set_sel(s);
      check("rst_pready", cur_ready, 0);
      check("rst_pslverr", cur_err, 0);
      check("rst_prdata", cur_rdata, 0);
      check("rst_wr_pulse", cur_pulse, 0);
      check_regs(s);
    end
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      set_sel(vecs[i].s);
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata,
           mk_exp(wc_of[vecs[i].s] + 1, vecs[i].wr, vecs[i].rdata, vecs[i].err), pls);
      check("wr_pulse", pls, vecs[i].pulse);
      if (vecs[i].wr && !vecs[i].err) mdl[vecs[i].s][(vecs[i].addr - Base) >> 2] = vecs[i].wdata;
      check_regs(vecs[i].s);
    end

    // PSEL & PENABLE without a setup phase must be ignored.
    set_sel(0);
    psel = 1'b1; penable = 1'b1;
    repeat (3) begin
      tick();
      check("idle_access_ignored", cur_ready, 0);
    end
    psel = 1'b0; penable = 1'b0;
    tick();

    // Write strobe lasts exactly one cycle.
    set_sel(1);
    xfer(1, Base + 32'hC, 32'h00C0_FFEE, mk_exp(2, 1, 0, 0), pls);
    check("wr_pulse_reg3", pls, 8'h08);
    mdl[1][3] = 32'h00C0_FFEE;
    tick();
    check("wr_pulse_single", cur_pulse, 0);

    // Abort: PSEL dropped in the second wait cycle.
    set_sel(2);
    paddr = Base + 32'h8; pwdata = 32'hAAAA_5555; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    seen = 0;
    repeat (6) begin
      tick();
      if (cur_ready) seen++;
      if (cur_pulse != 0) seen++;
    end
    check("abort_no_response", seen, 0);
    check_regs(2);
    xfer(0, Base + 32'h8, 32'h0, mk_exp(4, 0, 32'h0, 0), pls);
    xfer(1, Base + 32'h14, 32'h55, mk_exp(4, 1, 0, 0), pls);
    check("wr_pulse_after_abort", pls, 8'h20);
    mdl[2][5] = 32'h55;
    check_regs(2);

    // Reset during the wait phase of a write to reg 2.
    set_sel(2);
    paddr = Base + 32'h8; pwdata = 32'h2222_0000; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    tick();
    rst = 1'b0;
    check("midrst_pready", cur_ready, 0);
    check("midrst_pslverr", cur_err, 0);
    check("midrst_prdata", cur_rdata, 0);
    check("midrst_wr_pulse", cur_pulse, 0);
    foreach (mdl[s, k]) mdl[s][k] = '0;
    check_regs(0);
    check_regs(2);
    xfer(1, Base + 32'h8, 32'h2222, mk_exp(4, 1, 0, 0), pls);
    check("wr_pulse_after_rst", pls, 8'h04);
    mdl[2][2] = 32'h2222;
    check_regs(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
